// File: rtl/input_buffer_pingpong_if.sv
// Sample-stream handshake, random-access read port and status bundle for input_buffer_pingpong.
// master = producer/reader side, slave = the buffer itself.
interface input_buffer_pingpong_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 256,
  parameter int CHANNELS   = 2
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW   = $clog2(BLOCK_SIZE);

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  ready_in;
  logic                  block_ready;
  logic                  rd_bank;
  logic                  read_en;
  logic [CH_W-1:0]       read_chan;
  logic [AW-1:0]         read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  read_release;
  logic                  overflow;
  logic                  clear_overflow;
  logic [15:0]           drop_count;

  modport master (
    output valid_in, sample_in, read_en, read_chan, read_addr, read_release, clear_overflow,
    input  ready_in, block_ready, rd_bank, read_data, read_valid, overflow, drop_count
  );

  modport slave (
    input  valid_in, sample_in, read_en, read_chan, read_addr, read_release, clear_overflow,
    output ready_in, block_ready, rd_bank, read_data, read_valid, overflow, drop_count
  );
endinterface

// File: rtl/input_buffer_pingpong.sv
// Multi-channel ping-pong sample buffer: interleaved writes fill one bank, random-access reads drain the other.
// Latency: read_data/read_valid one cycle after read_en; block_ready the cycle after the final write.
// Backpressure: ready_in drops while both banks are full; offered samples are dropped and flagged (INPUT_BUFFER_DROP_COUNT_EN adds a drop counter).
module input_buffer_pingpong #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 256,
  parameter int CHANNELS   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input_buffer_pingpong_if.slave  bus
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW     = $clog2(BLOCK_SIZE);
  localparam int NWORDS = BLOCK_SIZE * CHANNELS;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0] NCH      = IDX_W'(CHANNELS);

  logic [DATA_WIDTH-1:0] mem_q [2][CHANNELS][BLOCK_SIZE];

  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  overflow_q, overflow_d;

  logic            ready, blk_rdy;
  logic            wr_fire, wr_last, drop, rel_fire, rd_fire;
  logic [CH_W-1:0] wr_chan;
  logic [AW-1:0]   wr_addr;

  assign ready    = !bank_full_q[wr_bank_q];
  assign blk_rdy  = bank_full_q[rd_bank_q];
  assign wr_fire  = bus.valid_in && ready;
  assign drop     = bus.valid_in && !ready;
  assign wr_last  = wr_fire && (wr_idx_q == LAST_IDX);
  assign rel_fire = bus.read_release && blk_rdy;
  assign rd_fire  = bus.read_en && blk_rdy;
  assign wr_chan  = CH_W'(wr_idx_q % NCH);
  assign wr_addr  = AW'(wr_idx_q / NCH);

  always_comb begin
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_idx_d     = wr_idx_q;
    bank_full_d  = bank_full_q;
    read_data_d  = read_data_q;
    read_valid_d = rd_fire;
    overflow_d   = overflow_q;

    if (wr_fire) begin
      wr_idx_d = wr_last ? '0 : wr_idx_q + 1'b1;
    end
    // Release and final write always target different banks, so both updates compose.
    if (rel_fire) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = !rd_bank_q;
    end
    if (wr_last) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = !wr_bank_q;
    end
    if (rd_fire) begin
      read_data_d = mem_q[rd_bank_q][bus.read_chan][bus.read_addr];
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      bank_full_q  <= 2'b00;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      bank_full_q  <= bank_full_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_chan][wr_addr] <= bus.sample_in;
    end
  end

`ifdef INPUT_BUFFER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (bus.clear_overflow) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (bus.clear_overflow) begin
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.drop_count = 16'h0000;
`endif

  assign bus.ready_in    = ready;
  assign bus.block_ready = blk_rdy;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.read_data   = read_data_q;
  assign bus.read_valid  = read_valid_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: doc/input_buffer_pingpong.md
Name: input_buffer_pingpong

Overview:
Parametrised successor to the single-bank sample input buffer: a multi-channel, double-buffered (ping-pong) sample store sitting between the ADC sample stream and the FIR/FFT engines. Interleaved samples fill one bank while the controller/DSP cores read a completed block from the other through a random-access read port. A valid/ready handshake applies backpressure when both banks are full, and an overflow flag records dropped samples.

Parameters:
DATA_WIDTH, 16, sample width in bits
BLOCK_SIZE, 256, samples per channel per block; power of two, >=2
CHANNELS, 2, interleaved channel count; power of two, >=1
CH_W, max(1,$clog2(CHANNELS)), channel index width (derived localparam)
AW, $clog2(BLOCK_SIZE), sample address width (derived localparam)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  sample_in valid
sample_in  in  DATA_WIDTH  interleaved sample: ch0,ch1,...,chN-1,ch0,...
ready_in  out  1  buffer can accept a sample this cycle
block_ready  out  1  a complete block is available on the read side
rd_bank  out  1  index of the bank currently presented for reading
read_en  in  1  read request
read_chan  in  CH_W  channel to read
read_addr  in  AW  sample index within the block
read_data  out  DATA_WIDTH  registered read result
read_valid  out  1  read_data valid (1-cycle pulse)
read_release  in  1  reader finished with the current block
overflow  out  1  sticky: a sample was offered while ready_in=0
clear_overflow  in  1  clears overflow
drop_count  out  16  dropped-sample counter (see Optional Feature)

Behaviour:
- Storage: 2 banks x CHANNELS x BLOCK_SIZE words. Memory contents are not reset.
- Reset (async): wr_bank=0, rd_bank=0, wr_idx=0, bank_full=2'b00, ready_in=1 (combinational), block_ready=0, read_data=0, read_valid=0, overflow=0, drop_count=0.
- Write accepted when valid_in && ready_in. Channel = wr_idx mod CHANNELS; address = wr_idx / CHANNELS.
- wr_idx counts 0..BLOCK_SIZE*CHANNELS-1. On an accepted write at the last index: bank_full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
- ready_in = !bank_full[wr_bank] (combinational).
- block_ready = bank_full[rd_bank] (combinational).
- read_release while block_ready: bank_full[rd_bank]<=0 and rd_bank toggles. read_release while !block_ready is ignored.
- Read: read_en sampled at edge N; read_data = bank[rd_bank][read_chan][read_addr] and read_valid=1 in cycle N+1.
  - If block_ready=0 at edge N, read_valid stays 0 and read_data holds its value.
  - read_valid deasserts the cycle after read_en drops.
- Read of the same address in the same cycle as read_release returns data from the pre-release bank.
- Simultaneous final write (filling wr_bank) and read_release (freeing rd_bank, the other bank): both take effect in the same cycle. block_ready then reflects the newly full bank on the next cycle.
- Both banks full: wr_bank==rd_bank and ready_in=0. A release in cycle N gives ready_in=1 in cycle N+1 and the writer resumes at index 0 of the freed bank.
- Overflow: valid_in && !ready_in sets overflow<=1 and the sample is discarded; wr_idx is unchanged.
  - clear_overflow clears overflow. Same-cycle set and clear: set wins.
- Reset asserted mid-block discards the partial block and any full blocks. The writer restarts at bank 0, index 0.

Optional Feature:
Macro INPUT_BUFFER_DROP_COUNT_EN.
- Defined: drop_count increments by 1 on every discarded sample and saturates at 16'hFFFF. clear_overflow also zeroes it; same-cycle drop and clear gives drop_count=1.
- Undefined: drop_count tied to 16'h0000 and no counter logic is synthesised. overflow behaviour is identical in both builds.

Test Plan:
(Bench uses DATA_WIDTH=16, BLOCK_SIZE=4, CHANNELS=2.)
- Reset, then write 8 samples 0x0010..0x0017 back-to-back -> block_ready=1 the cycle after the 8th write, rd_bank=0.
  - Reading chan=1 addr=2 gives read_data=0x0015, read_valid pulsed one cycle later.
- Write 16 samples with no release -> ready_in=0 after the 16th; 17th sample (0xBEEF) dropped, overflow=1, drop_count=1 (macro on) or 0 (macro off).
  - read_release -> ready_in=1 next cycle; rd_bank=1 and block_ready stays 1.
- Final write of bank 1 coincident with read_release of bank 0 -> rd_bank=1, block_ready=1, wr_bank=0, ready_in=1.
- read_en with block_ready=0 -> read_valid stays 0 and read_data keeps its prior value.
  - read_release with block_ready=0 -> no change to rd_bank.
- Assert reset after 5 of 8 writes -> all outputs at reset values.
  - The next 8 writes (0x0100..0x0107) produce block chan0 addr0=0x0100 in bank 0.
- 70000 dropped samples with macro on -> drop_count=16'hFFFF.
  - clear_overflow -> overflow=0, drop_count=0.
